// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, LSB first, one full-adder cell plus a carry
// flip-flop. Operands are captured on an accepted start. Results (sum, carry-out,
// signed overflow) are held until the next operation completes.
module serial_adder #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] num1,
    input  logic [N-1:0] num2,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   ps_q, ps_d;
    logic           c_q, c_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    // Full-adder cell, fed by the low bits of the operand shift registers
    logic           s_c;
    logic           carry_c;
    logic [N-1:0]   ps_next_c;

    always_comb begin
        s_c       = a_q[0] ^ b_q[0] ^ c_q;
        carry_c   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        ps_next_c = {s_c, ps_q[N-1:1]};
    end

    // Next-state and datapath update; every register holds unless its case says otherwise
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ps_d    = ps_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = num1;
                    b_d     = num2;
                    ps_d    = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d  = {1'b0, a_q[N-1:1]};
                b_d  = {1'b0, b_q[N-1:1]};
                ps_d = ps_next_c;
                c_d  = carry_c;
                if (cnt_q == CW'(N - 1)) begin
                    // Last bit: c_q is the carry into the MSB, carry_c the carry out of it
                    cnt_d   = '0;
                    sum_d   = ps_next_c;
                    cout_d  = carry_c;
                    ovf_d   = c_q ^ carry_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (start) begin
                    a_d     = num1;
                    b_d     = num2;
                    ps_d    = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ps_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ps_q    <= ps_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Status is decoded from the state register only; no path from inputs
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
